// File: rtl/riscv_biu_arb2.sv
// Two-requester arbiter in front of a single BIU port.
// Requester 0 is the instruction-fetch side, requester 1 the data side.
// Grants are round-robin per accepted transfer, bus locks pin the grant to
// the lock owner, and an in-order owner FIFO steers every response back to
// the requester that issued the transfer.
module riscv_biu_arb2 #(
  parameter int XLEN        = 32,
  parameter int PLEN        = XLEN,
  parameter int BIUTAG_SIZE = $clog2(XLEN/16),
  parameter int DEPTH       = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,

  // requester 0 (instruction fetch)
  input  logic                   m0_stb_i,
  output logic                   m0_stb_ack_o,
  output logic                   m0_d_ack_o,
  input  logic [PLEN-1:0]        m0_adri_i,
  input  logic [2:0]             m0_size_i,
  input  logic [2:0]             m0_type_i,
  input  logic [2:0]             m0_prot_i,
  input  logic                   m0_lock_i,
  input  logic                   m0_we_i,
  input  logic [XLEN-1:0]        m0_d_i,
  input  logic [BIUTAG_SIZE-1:0] m0_tagi_i,
  output logic [XLEN-1:0]        m0_q_o,
  output logic [PLEN-1:0]        m0_adro_o,
  output logic [BIUTAG_SIZE-1:0] m0_tago_o,
  output logic                   m0_ack_o,
  output logic                   m0_err_o,

  // requester 1 (data memory)
  input  logic                   m1_stb_i,
  output logic                   m1_stb_ack_o,
  output logic                   m1_d_ack_o,
  input  logic [PLEN-1:0]        m1_adri_i,
  input  logic [2:0]             m1_size_i,
  input  logic [2:0]             m1_type_i,
  input  logic [2:0]             m1_prot_i,
  input  logic                   m1_lock_i,
  input  logic                   m1_we_i,
  input  logic [XLEN-1:0]        m1_d_i,
  input  logic [BIUTAG_SIZE-1:0] m1_tagi_i,
  output logic [XLEN-1:0]        m1_q_o,
  output logic [PLEN-1:0]        m1_adro_o,
  output logic [BIUTAG_SIZE-1:0] m1_tago_o,
  output logic                   m1_ack_o,
  output logic                   m1_err_o,

  // shared downstream BIU port
  output logic                   biu_stb_o,
  input  logic                   biu_stb_ack_i,
  input  logic                   biu_d_ack_i,
  output logic [PLEN-1:0]        biu_adri_o,
  output logic [2:0]             biu_size_o,
  output logic [2:0]             biu_type_o,
  output logic                   biu_lock_o,
  output logic                   biu_we_o,
  output logic [2:0]             biu_prot_o,
  output logic [XLEN-1:0]        biu_d_o,
  output logic [BIUTAG_SIZE-1:0] biu_tagi_o,
  input  logic [XLEN-1:0]        biu_q_i,
  input  logic [PLEN-1:0]        biu_adro_i,
  input  logic [BIUTAG_SIZE-1:0] biu_tago_i,
  input  logic                   biu_ack_i,
  input  logic                   biu_err_i,

  output logic                   spurious_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic             last_gnt;
  logic             locked;
  logic             lock_owner;
  logic             sel;
  logic             sel_stb;
  logic             sel_lock;
  logic             full;
  logic             empty;
  logic             accept;
  logic             rsp;
  logic             pop;
  logic             owner;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [DEPTH-1:0] owner_q;

  // pointer advance with explicit wrap so non-power-of-2 depths also work
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == LAST_PTR) return '0;
    return p + 1'b1;
  endfunction

  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  assign owner  = owner_q[rd_ptr];
  assign accept = biu_stb_o & biu_stb_ack_i;
  assign rsp    = biu_ack_i | biu_err_i;
  assign pop    = rsp & ~empty;

  // a response with nothing outstanding belongs to nobody
  assign spurious_o = rsp & empty;

  // grant selection: lock owner first, then lone requester, then round-robin
  always_comb begin
    sel = last_gnt;
    if (locked)                 sel = lock_owner;
    else if (m0_stb_i ^ m1_stb_i) sel = m1_stb_i;
    else if (m0_stb_i & m1_stb_i) sel = ~last_gnt;
  end

  // downstream request mux; the strobe is masked by the registered full flag
  always_comb begin
    sel_stb    = sel ? m1_stb_i  : m0_stb_i;
    sel_lock   = sel ? m1_lock_i : m0_lock_i;
    biu_stb_o  = sel_stb & ~full;
    biu_adri_o = sel ? m1_adri_i : m0_adri_i;
    biu_size_o = sel ? m1_size_i : m0_size_i;
    biu_type_o = sel ? m1_type_i : m0_type_i;
    biu_prot_o = sel ? m1_prot_i : m0_prot_i;
    biu_lock_o = sel_lock;
    biu_we_o   = sel ? m1_we_i   : m0_we_i;
    biu_d_o    = sel ? m1_d_i    : m0_d_i;
    biu_tagi_o = sel ? m1_tagi_i : m0_tagi_i;
  end

  // request handshakes go only to the selected requester
  always_comb begin
    m0_stb_ack_o = ~sel & biu_stb_ack_i & ~full;
    m1_stb_ack_o =  sel & biu_stb_ack_i & ~full;
    m0_d_ack_o   = ~sel & biu_d_ack_i;
    m1_d_ack_o   =  sel & biu_d_ack_i;
  end

  // response routing to the FIFO head; everything zero when nothing is owed
  always_comb begin
    m0_ack_o  = 1'b0;
    m0_err_o  = 1'b0;
    m0_q_o    = '0;
    m0_adro_o = '0;
    m0_tago_o = '0;
    m1_ack_o  = 1'b0;
    m1_err_o  = 1'b0;
    m1_q_o    = '0;
    m1_adro_o = '0;
    m1_tago_o = '0;
    if (!empty) begin
      if (owner) begin
        m1_ack_o  = biu_ack_i;
        m1_err_o  = biu_err_i;
        m1_q_o    = biu_q_i;
        m1_adro_o = biu_adro_i;
        m1_tago_o = biu_tago_i;
      end else begin
        m0_ack_o  = biu_ack_i;
        m0_err_o  = biu_err_i;
        m0_q_o    = biu_q_i;
        m0_adro_o = biu_adro_i;
        m0_tago_o = biu_tago_i;
      end
    end
  end

  // round-robin history and bus-lock state, updated on accepted transfers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_gnt   <= 1'b1;
      locked     <= 1'b0;
      lock_owner <= 1'b0;
    end else if (accept) begin
      last_gnt <= sel;
      if (sel_lock) begin
        locked     <= 1'b1;
        lock_owner <= sel;
      end else if (locked && (sel == lock_owner)) begin
        locked <= 1'b0;
      end
    end
  end

  // owner FIFO pointers and occupancy
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)    rd_ptr <= ptr_inc(rd_ptr);
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // owner FIFO storage; entries are only read while count says they are valid
  always_ff @(posedge clk_i) begin
    if (accept) owner_q[wr_ptr] <= sel;
  end

endmodule

// File: tb/tb_riscv_biu_arb2.sv
// Directed testbench for riscv_biu_arb2 (XLEN=32, DEPTH=2).
module tb_riscv_biu_arb2;

  localparam int XLEN = 32;
  localparam int PLEN = 32;
  localparam int TW   = 1;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;

  logic            m0_stb_i, m0_stb_ack_o, m0_d_ack_o, m0_lock_i, m0_we_i;
  logic [PLEN-1:0] m0_adri_i, m0_adro_o;
  logic [2:0]      m0_size_i, m0_type_i, m0_prot_i;
  logic [XLEN-1:0] m0_d_i, m0_q_o;
  logic [TW-1:0]   m0_tagi_i, m0_tago_o;
  logic            m0_ack_o, m0_err_o;

  logic            m1_stb_i, m1_stb_ack_o, m1_d_ack_o, m1_lock_i, m1_we_i;
  logic [PLEN-1:0] m1_adri_i, m1_adro_o;
  logic [2:0]      m1_size_i, m1_type_i, m1_prot_i;
  logic [XLEN-1:0] m1_d_i, m1_q_o;
  logic [TW-1:0]   m1_tagi_i, m1_tago_o;
  logic            m1_ack_o, m1_err_o;

  logic            biu_stb_o, biu_stb_ack_i, biu_d_ack_i, biu_lock_o, biu_we_o;
  logic [PLEN-1:0] biu_adri_o, biu_adro_i;
  logic [2:0]      biu_size_o, biu_type_o, biu_prot_o;
  logic [XLEN-1:0] biu_d_o, biu_q_i;
  logic [TW-1:0]   biu_tagi_o, biu_tago_i;
  logic            biu_ack_i, biu_err_i, spurious_o;

  int n_tests = 0;
  int n_fail  = 0;

  riscv_biu_arb2 #(.XLEN(XLEN), .PLEN(PLEN), .BIUTAG_SIZE(TW), .DEPTH(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_stb_i(m0_stb_i), .m0_stb_ack_o(m0_stb_ack_o), .m0_d_ack_o(m0_d_ack_o),
    .m0_adri_i(m0_adri_i), .m0_size_i(m0_size_i), .m0_type_i(m0_type_i),
    .m0_prot_i(m0_prot_i), .m0_lock_i(m0_lock_i), .m0_we_i(m0_we_i),
    .m0_d_i(m0_d_i), .m0_tagi_i(m0_tagi_i), .m0_q_o(m0_q_o),
    .m0_adro_o(m0_adro_o), .m0_tago_o(m0_tago_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_stb_i(m1_stb_i), .m1_stb_ack_o(m1_stb_ack_o), .m1_d_ack_o(m1_d_ack_o),
    .m1_adri_i(m1_adri_i), .m1_size_i(m1_size_i), .m1_type_i(m1_type_i),
    .m1_prot_i(m1_prot_i), .m1_lock_i(m1_lock_i), .m1_we_i(m1_we_i),
    .m1_d_i(m1_d_i), .m1_tagi_i(m1_tagi_i), .m1_q_o(m1_q_o),
    .m1_adro_o(m1_adro_o), .m1_tago_o(m1_tago_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .biu_stb_o(biu_stb_o), .biu_stb_ack_i(biu_stb_ack_i), .biu_d_ack_i(biu_d_ack_i),
    .biu_adri_o(biu_adri_o), .biu_size_o(biu_size_o), .biu_type_o(biu_type_o),
    .biu_lock_o(biu_lock_o), .biu_we_o(biu_we_o), .biu_prot_o(biu_prot_o),
    .biu_d_o(biu_d_o), .biu_tagi_o(biu_tagi_o), .biu_q_i(biu_q_i),
    .biu_adro_i(biu_adro_i), .biu_tago_i(biu_tago_i), .biu_ack_i(biu_ack_i),
    .biu_err_i(biu_err_i), .spurious_o(spurious_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance past the next rising edge, then settle 1ns
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    m0_stb_i = 0; m0_lock_i = 0; m0_we_i = 0; m0_adri_i = 32'h1000;
    m0_size_i = 3'd2; m0_type_i = 3'd0; m0_prot_i = 3'd0; m0_d_i = '0; m0_tagi_i = '0;
    m1_stb_i = 0; m1_lock_i = 0; m1_we_i = 0; m1_adri_i = 32'h2000;
    m1_size_i = 3'd2; m1_type_i = 3'd0; m1_prot_i = 3'd0; m1_d_i = '0; m1_tagi_i = '0;
    biu_stb_ack_i = 0; biu_d_ack_i = 0; biu_ack_i = 0; biu_err_i = 0;
    biu_q_i = '0; biu_adro_i = '0; biu_tago_i = '0;
  endtask

  task automatic do_reset();
    rst_i = 1;
    step();
    step();
    rst_i = 0;
    #1;
  endtask

  initial begin
    idle();
    step();
    #1;
    check("rst_biu_stb", biu_stb_o, 0);
    check("rst_spurious", spurious_o, 0);
    check("rst_m0_ack", m0_ack_o, 0);
    step();
    rst_i = 0;
    #1;

    // single m0 read, response two cycles later
    m0_stb_i = 1; m0_adri_i = 32'h100; biu_stb_ack_i = 1;
    #1;
    check("t1_biu_stb", biu_stb_o, 1);
    check("t1_biu_adri", biu_adri_o, 32'h100);
    check("t1_m0_stb_ack", m0_stb_ack_o, 1);
    check("t1_m1_stb_ack", m1_stb_ack_o, 0);
    step();
    idle();
    step();
    biu_ack_i = 1; biu_q_i = 32'hDEADBEEF; biu_tago_i = 1; biu_adro_i = 32'h100;
    #1;
    check("t1_m0_ack", m0_ack_o, 1);
    check("t1_m0_q", m0_q_o, 32'hDEADBEEF);
    check("t1_m0_tago", m0_tago_o, 1);
    check("t1_m0_adro", m0_adro_o, 32'h100);
    check("t1_m1_ack", m1_ack_o, 0);
    check("t1_m1_q", m1_q_o, 0);
    check("t1_m1_tago", m1_tago_o, 0);
    check("t1_spurious", spurious_o, 0);
    step();
    // FIFO is empty again: another ack is spurious
    #1;
    check("sp_spurious", spurious_o, 1);
    check("sp_m0_ack", m0_ack_o, 0);
    check("sp_m1_ack", m1_ack_o, 0);
    step();
    idle();
    #1;
    check("sp_pulse_end", spurious_o, 0);

    // alternation with both requesting
    do_reset();
    m0_stb_i = 1; m1_stb_i = 1; biu_stb_ack_i = 1;
    #1;
    check("t2_g0_adri", biu_adri_o, 32'h1000);
    check("t2_g0_m0ack", m0_stb_ack_o, 1);
    step();
    check("t2_g1_adri", biu_adri_o, 32'h2000);
    check("t2_g1_m1ack", m1_stb_ack_o, 1);
    step();
    biu_ack_i = 1; biu_q_i = 32'hA0;
    #1;
    check("t2_full_stb", biu_stb_o, 0);
    check("t2_full_m0sa", m0_stb_ack_o, 0);
    check("t2_full_m1sa", m1_stb_ack_o, 0);
    check("t2_r0_m0", m0_ack_o, 1);
    check("t2_r0_m1", m1_ack_o, 0);
    step();
    biu_q_i = 32'hA1;
    #1;
    check("t2_g2_adri", biu_adri_o, 32'h1000);
    check("t2_r1_m1", m1_ack_o, 1);
    check("t2_r1_m1q", m1_q_o, 32'hA1);
    check("t2_r1_m0q", m0_q_o, 0);
    step();
    #1;
    check("t2_g3_adri", biu_adri_o, 32'h2000);
    check("t2_r2_m0", m0_ack_o, 1);
    step();
    m0_stb_i = 0; m1_stb_i = 0; biu_stb_ack_i = 0;
    #1;
    check("t2_r3_m1", m1_ack_o, 1);
    check("t2_r3_m0", m0_ack_o, 0);
    step();
    idle();
    #1;

    // fill with m0 only, release one slot
    m0_stb_i = 1; biu_stb_ack_i = 1;
    #1;
    check("t3_c1_stb", biu_stb_o, 1);
    step();
    check("t3_c2_stb", biu_stb_o, 1);
    step();
    biu_ack_i = 1;
    #1;
    check("t3_c3_stb", biu_stb_o, 0);
    check("t3_c3_m0sa", m0_stb_ack_o, 0);
    check("t3_c3_m0ack", m0_ack_o, 1);
    step();
    biu_ack_i = 0; biu_stb_ack_i = 0;
    #1;
    check("t3_c4_stb", biu_stb_o, 1);
    m0_stb_i = 0; biu_ack_i = 1;
    #1;
    check("t3_drain", m0_ack_o, 1);
    step();
    idle();
    #1;

    // m1 lock starves m0
    m1_stb_i = 1; m1_lock_i = 1; biu_stb_ack_i = 1;
    #1;
    check("t4_lock_stb", biu_stb_o, 1);
    check("t4_lock_out", biu_lock_o, 1);
    check("t4_lock_m1sa", m1_stb_ack_o, 1);
    step();
    m1_stb_i = 0; m1_lock_i = 0; m0_stb_i = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("t4_starve_stb%0d", i), biu_stb_o, 0);
      check($sformatf("t4_starve_sa%0d", i), m0_stb_ack_o, 0);
      step();
    end
    m1_stb_i = 1; m1_adri_i = 32'h2004; biu_ack_i = 1;
    #1;
    check("t4_unlock_adri", biu_adri_o, 32'h2004);
    check("t4_unlock_m1sa", m1_stb_ack_o, 1);
    check("t4_unlock_m0sa", m0_stb_ack_o, 0);
    check("t4_lockrsp_m1", m1_ack_o, 1);
    step();
    biu_ack_i = 0; biu_stb_ack_i = 0;
    #1;
    check("t4_next_adri", biu_adri_o, 32'h1000);
    check("t4_next_stb", biu_stb_o, 1);
    m0_stb_i = 0; m1_stb_i = 0; biu_ack_i = 1;
    #1;
    check("t4_drain_m1", m1_ack_o, 1);
    step();
    idle();
    #1;

    // reset with two transfers in flight
    m0_stb_i = 1; biu_stb_ack_i = 1;
    step();
    step();
    biu_stb_ack_i = 0;
    #1;
    check("t6_full_stb", biu_stb_o, 0);
    rst_i = 1;
    #1;
    check("t6_async_stb", biu_stb_o, 1);
    m0_stb_i = 0;
    step();
    rst_i = 0;
    #1;
    for (int i = 0; i < 2; i++) begin
      biu_ack_i = 1;
      #1;
      check($sformatf("t6_spur%0d", i), spurious_o, 1);
      check($sformatf("t6_m0ack%0d", i), m0_ack_o, 0);
      check($sformatf("t6_m1ack%0d", i), m1_ack_o, 0);
      step();
      biu_ack_i = 0;
      step();
    end

    // m1 write with data ack, then error response
    m1_stb_i = 1; m1_we_i = 1; m1_d_i = 32'h55AA; biu_stb_ack_i = 1; biu_d_ack_i = 1;
    #1;
    check("t7_we", biu_we_o, 1);
    check("t7_d", biu_d_o, 32'h55AA);
    check("t7_m1_dack", m1_d_ack_o, 1);
    check("t7_m0_dack", m0_d_ack_o, 0);
    step();
    idle();
    biu_err_i = 1;
    #1;
    check("t7_m1_err", m1_err_o, 1);
    check("t7_m1_ack", m1_ack_o, 0);
    check("t7_m0_err", m0_err_o, 0);
    check("t7_spur", spurious_o, 0);
    step();
    #1;
    check("t7_after_spur", spurious_o, 1);
    step();
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
